fifo_rd_ctrl: RTL and testbench

Read-side pointer and flag controller for the dual-clock FIFO, running entirely in the read clock domain. It synchronises the incoming write Gray pointer and maintains the binary/Gray read pointers. It generates registered empty, almost-empty and fill-level outputs and drives the RAM read port. Generalises the earlier read controller with a synchroniser depth parameter, programmable almost-empty, sticky underflow and an optional first-word-fall-through (FWFT) output stage.

---
 rtl/fifo_pkg.sv | 35 +++
 rtl/fifo_rd_ctrl_if.sv | 38 +++
 rtl/gray_ptr_sync.sv | 38 +++
 rtl/fifo_rd_ctrl.sv | 144 ++++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg : shared FWFT state encoding and Gray/binary pointer helpers
// Rev 1.0
// ============================================================================
package fifo_pkg;

  typedef enum logic [1:0] {
    FWFT_IDLE  = 2'd0,
    FWFT_FETCH = 2'd1,
    FWFT_HOLD  = 2'd2
  } fwft_state_t;

  // Helpers operate on a 32-bit container; callers zero-extend and size-cast.
  localparam int MAX_PTR_WIDTH = 32;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(input logic [MAX_PTR_WIDTH-1:0] g);
    logic [MAX_PTR_WIDTH-1:0] b;
    b[MAX_PTR_WIDTH-1] = g[MAX_PTR_WIDTH-1];
    for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
// fifo_rd_ctrl_if : read-side controller bus (write pointer in, RAM/flags out)
// Rev 1.0
// ============================================================================
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
);
  localparam int PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0]         w_gptr_i;
  logic                  r_req_i;
  logic                  r_uf_clr_i;
  logic                  r_en_o;
  logic [ADDR_WIDTH-1:0] r_addr_o;
  logic [PW-1:0]         r_gptr_o;
  logic                  r_valid_o;
  logic                  r_empty_o;
  logic                  r_aempty_o;
  logic [PW-1:0]         r_level_o;
  logic                  r_underflow_o;

  modport slave (
    input  w_gptr_i, r_req_i, r_uf_clr_i,
    output r_en_o, r_addr_o, r_gptr_o, r_valid_o, r_empty_o,
           r_aempty_o, r_level_o, r_underflow_o
  );

  modport master (
    output w_gptr_i, r_req_i, r_uf_clr_i,
    input  r_en_o, r_addr_o, r_gptr_o, r_valid_o, r_empty_o,
           r_aempty_o, r_level_o, r_underflow_o
  );

endinterface
`default_nettype wire

// File: rtl/gray_ptr_sync.sv
`default_nettype none
// ============================================================================
// gray_ptr_sync : multi-flop synchroniser for a Gray pointer plus binary decode
// Rev 1.0
// ============================================================================
module gray_ptr_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] gray_sync,
  output logic [WIDTH-1:0] bin_sync
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign gray_sync = stage[SYNC_STAGES-1];
  assign bin_sync  = WIDTH'(gray2bin(32'(gray_sync)));

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_rd_ctrl : read-domain pointer/flag controller with optional FWFT stage
// Rev 1.0
// ============================================================================
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 0,
  parameter int AE_THRESH   = 4
) (
  input  logic           r_clk_i,
  input  logic           rst_i,
  fifo_rd_ctrl_if.slave  bus
);

  localparam int            PW       = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  logic [PW-1:0] wg_sync;
  logic [PW-1:0] wb_sync;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] rd_gray_next;
  logic [PW-1:0] rd_gray;
  logic [PW-1:0] level;
  logic [PW-1:0] level_next;
  logic          mem_empty;
  logic          aempty;
  logic          fetch;
  logic          valid;
  logic          empty_flag;
  logic          underflow;
  logic          uf_set;

  gray_ptr_sync #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk       (r_clk_i),
    .rst       (rst_i),
    .gray_in   (bus.w_gptr_i),
    .gray_sync (wg_sync),
    .bin_sync  (wb_sync)
  );

  assign rd_bin_next  = rd_bin + PW'(fetch);
  assign rd_gray_next = PW'(bin2gray(32'(rd_bin_next)));
  assign level_next   = wb_sync - rd_bin_next;

  // Flags look at the post-fetch pointer so empty is never late by a word.
  always_ff @(posedge r_clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_bin    <= '0;
      rd_gray   <= '0;
      mem_empty <= 1'b1;
      level     <= '0;
      aempty    <= 1'b1;
    end else begin
      rd_bin    <= rd_bin_next;
      rd_gray   <= rd_gray_next;
      mem_empty <= (rd_gray_next == wg_sync);
      level     <= level_next;
      aempty    <= (level_next <= AE_LIMIT);
    end
  end

  if (FWFT != 0) begin : g_fwft
    fwft_state_t state;

    assign fetch = ~mem_empty &
                   ((state == FWFT_IDLE) | ((state == FWFT_HOLD) & bus.r_req_i));
    assign empty_flag = ~valid;

    always_ff @(posedge r_clk_i or posedge rst_i) begin
      if (rst_i) begin
        state <= FWFT_IDLE;
        valid <= 1'b0;
      end else begin
        case (state)
          FWFT_IDLE: begin
            valid <= 1'b0;
            if (!mem_empty) begin
              state <= FWFT_FETCH;
            end
          end
          FWFT_FETCH: begin
            state <= FWFT_HOLD;
            valid <= 1'b1;
          end
          FWFT_HOLD: begin
            if (bus.r_req_i && mem_empty) begin
              state <= FWFT_IDLE;
              valid <= 1'b0;
            end else begin
              valid <= 1'b1;
            end
          end
          default: begin
            state <= FWFT_IDLE;
            valid <= 1'b0;
          end
        endcase
      end
    end
  end else begin : g_std
    assign fetch      = bus.r_req_i & ~mem_empty;
    assign empty_flag = mem_empty;

    always_ff @(posedge r_clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid <= 1'b0;
      end else begin
        valid <= fetch;
      end
    end
  end

  // Set has priority so a pop on empty is never lost to a coincident clear.
  assign uf_set = bus.r_req_i & empty_flag;

  always_ff @(posedge r_clk_i or posedge rst_i) begin
    if (rst_i) begin
      underflow <= 1'b0;
    end else if (uf_set) begin
      underflow <= 1'b1;
    end else if (bus.r_uf_clr_i) begin
      underflow <= 1'b0;
    end
  end

  assign bus.r_en_o        = fetch;
  assign bus.r_addr_o      = rd_bin[ADDR_WIDTH-1:0];
  assign bus.r_gptr_o      = rd_gray;
  assign bus.r_valid_o     = valid;
  assign bus.r_empty_o     = empty_flag;
  assign bus.r_aempty_o    = aempty;
  assign bus.r_level_o     = level;
  assign bus.r_underflow_o = underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fifo_rd_ctrl : scoreboard bench for standard and FWFT read controllers
// Rev 1.0
// ============================================================================
module tb_fifo_rd_ctrl;

  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.ADDR_WIDTH(AW)) s_if ();
  fifo_rd_ctrl_if #(.ADDR_WIDTH(AW)) f_if ();

  fifo_rd_ctrl #(
    .ADDR_WIDTH (AW), .SYNC_STAGES (2), .FWFT (0), .AE_THRESH (4)
  ) dut_std (
    .r_clk_i (clk), .rst_i (rst), .bus (s_if.slave)
  );

  fifo_rd_ctrl #(
    .ADDR_WIDTH (AW), .SYNC_STAGES (2), .FWFT (1), .AE_THRESH (4)
  ) dut_fwft (
    .r_clk_i (clk), .rst_i (rst), .bus (f_if.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [AW-1:0] s_q [$];
  logic [AW-1:0] f_q [$];
  logic [AW:0]   s_wbin;
  logic [AW:0]   f_wbin;
  int            s_fetch_cnt;
  int            f_fetch_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_write(input int n);
    for (int i = 0; i < n; i++) begin
      s_q.push_back(s_wbin[AW-1:0]);
      s_wbin = s_wbin + 1'b1;
    end
    s_if.w_gptr_i = gray(s_wbin);
  endtask

  task automatic f_write(input int n);
    for (int i = 0; i < n; i++) begin
      f_q.push_back(f_wbin[AW-1:0]);
      f_wbin = f_wbin + 1'b1;
    end
    f_if.w_gptr_i = gray(f_wbin);
  endtask

  // Every RAM fetch must consume the oldest written address.
  always @(negedge clk) begin
    if (!rst && s_if.r_en_o) begin
      s_fetch_cnt++;
      check_val("s_fetch_pending", 32'(s_q.size() > 0), 32'd1);
      if (s_q.size() > 0) check_val("s_addr", 32'(s_if.r_addr_o), 32'(s_q.pop_front()));
    end
    if (!rst && f_if.r_en_o) begin
      f_fetch_cnt++;
      check_val("f_fetch_pending", 32'(f_q.size() > 0), 32'd1);
      if (f_q.size() > 0) check_val("f_addr", 32'(f_if.r_addr_o), 32'(f_q.pop_front()));
    end
  end

  initial begin
    int n;
    int toggles;
    logic prev_msb;

    rst = 1'b1;
    s_if.w_gptr_i = '0; s_if.r_req_i = 1'b0; s_if.r_uf_clr_i = 1'b0;
    f_if.w_gptr_i = '0; f_if.r_req_i = 1'b0; f_if.r_uf_clr_i = 1'b0;
    s_wbin = '0; f_wbin = '0;
    s_fetch_cnt = 0; f_fetch_cnt = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_empty",  32'(s_if.r_empty_o),  32'd1);
    check_val("rst_aempty", 32'(s_if.r_aempty_o), 32'd1);
    check_val("rst_level",  32'(s_if.r_level_o),  32'd0);
    check_val("rst_valid",  32'(s_if.r_valid_o),  32'd0);
    check_val("rst_f_empty", 32'(f_if.r_empty_o), 32'd1);
    tick();
    rst = 1'b0;

    // Three words appear; empty must fall exactly three edges later.
    tick();
    s_write(3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("sync_empty_hold", 32'(s_if.r_empty_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_val("sync_empty_fall", 32'(s_if.r_empty_o),  32'd0);
    check_val("sync_level3",     32'(s_if.r_level_o),  32'd3);
    check_val("sync_aempty",     32'(s_if.r_aempty_o), 32'd1);

    tick();
    s_if.r_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("pop_en", 32'(s_if.r_en_o), 32'd1);
      tick();
    end
    s_if.r_req_i = 1'b0;
    @(negedge clk);
    check_val("pop_empty", 32'(s_if.r_empty_o), 32'd1);
    check_val("pop_level", 32'(s_if.r_level_o), 32'd0);
    check_val("pop_valid", 32'(s_if.r_valid_o), 32'd1);
    check_val("pop_addr",  32'(s_if.r_addr_o),  32'd3);

    // Underflow set, clear, and set-beats-clear.
    tick();
    s_if.r_req_i = 1'b1;
    @(negedge clk);
    check_val("uf_no_fetch", 32'(s_if.r_en_o), 32'd0);
    tick();
    s_if.r_req_i = 1'b0;
    @(negedge clk);
    check_val("uf_set",  32'(s_if.r_underflow_o), 32'd1);
    check_val("uf_addr", 32'(s_if.r_addr_o),      32'd3);
    tick(); s_if.r_uf_clr_i = 1'b1;
    tick(); s_if.r_uf_clr_i = 1'b0;
    @(negedge clk);
    check_val("uf_clr", 32'(s_if.r_underflow_o), 32'd0);
    tick(); s_if.r_req_i = 1'b1; s_if.r_uf_clr_i = 1'b1;
    tick(); s_if.r_req_i = 1'b0; s_if.r_uf_clr_i = 1'b0;
    @(negedge clk);
    check_val("uf_set_wins", 32'(s_if.r_underflow_o), 32'd1);

    // Asynchronous reset with data resident and underflow pending.
    tick();
    s_write(2);
    repeat (4) tick();
    @(negedge clk);
    check_val("mid_level2", 32'(s_if.r_level_o), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_val("arst_empty",  32'(s_if.r_empty_o),     32'd1);
    check_val("arst_aempty", 32'(s_if.r_aempty_o),    32'd1);
    check_val("arst_level",  32'(s_if.r_level_o),     32'd0);
    check_val("arst_gptr",   32'(s_if.r_gptr_o),      32'd0);
    check_val("arst_uf",     32'(s_if.r_underflow_o), 32'd0);
    s_q.delete(); s_wbin = '0; s_if.w_gptr_i = '0;
    tick(); tick();
    rst = 1'b0;

    // Interleaved writes/pops across two pointer wraps.
    s_fetch_cnt = 0;
    toggles = 0;
    s_if.r_req_i = 1'b1;
    prev_msb = s_if.r_gptr_o[AW];
    for (int i = 0; i < 20; i++) begin
      tick();
      s_write(1);
      @(negedge clk);
      if (s_if.r_gptr_o[AW] != prev_msb) begin toggles++; prev_msb = s_if.r_gptr_o[AW]; end
    end
    for (int i = 0; i < 30 && s_q.size() > 0; i++) begin
      tick();
      @(negedge clk);
      if (s_if.r_gptr_o[AW] != prev_msb) begin toggles++; prev_msb = s_if.r_gptr_o[AW]; end
    end
    tick();
    s_if.r_req_i = 1'b0;
    @(negedge clk);
    if (s_if.r_gptr_o[AW] != prev_msb) toggles++;
    check_val("wrap_drained",  32'(s_q.size()),      32'd0);
    check_val("wrap_fetches",  32'(s_fetch_cnt),     32'd20);
    check_val("wrap_msb_togs", 32'(toggles),         32'd2);
    check_val("wrap_gptr",     32'(s_if.r_gptr_o),   32'(gray(s_wbin)));
    check_val("wrap_addr",     32'(s_if.r_addr_o),   32'd4);
    check_val("wrap_empty",    32'(s_if.r_empty_o),  32'd1);
    tick(); s_if.r_uf_clr_i = 1'b1;
    tick(); s_if.r_uf_clr_i = 1'b0;

    // Almost-empty boundary at AE_THRESH = 4.
    tick();
    s_write(6);
    n = 0;
    while (s_if.r_level_o != 6 && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    check_val("ae_level6",  32'(s_if.r_level_o),  32'd6);
    check_val("ae_clear6",  32'(s_if.r_aempty_o), 32'd0);
    tick(); s_if.r_req_i = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check_val("ae_level5", 32'(s_if.r_level_o),  32'd5);
    check_val("ae_clear5", 32'(s_if.r_aempty_o), 32'd0);
    tick(); s_if.r_req_i = 1'b0;
    @(negedge clk);
    check_val("ae_level4", 32'(s_if.r_level_o),  32'd4);
    check_val("ae_set4",   32'(s_if.r_aempty_o), 32'd1);
    tick(); s_if.r_req_i = 1'b1;
    for (int i = 0; i < 20 && s_q.size() > 0; i++) begin
      tick();
    end
    s_if.r_req_i = 1'b0;
    @(negedge clk);
    check_val("ae_drained", 32'(s_q.size()), 32'd0);

    // FWFT: four words with the consumer always ready.
    tick();
    f_if.r_req_i = 1'b1;
    f_write(4);
    n = 0;
    while (!f_if.r_valid_o && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check_val("fwft_first_valid", 32'(n), 32'd5);
    n = 0;
    while (f_if.r_valid_o && n < 20) begin
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    check_val("fwft_valid_run", 32'(n),                32'd4);
    check_val("fwft_empty",     32'(f_if.r_empty_o),   32'd1);
    check_val("fwft_en_idle",   32'(f_if.r_en_o),      32'd0);
    check_val("fwft_fetches",   32'(f_fetch_cnt),      32'd4);
    check_val("fwft_drained",   32'(f_q.size()),       32'd0);
    f_if.r_req_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
